instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 39 +++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module : instr_fetch_unit_if
// Brief  : Control, loader and fetch-output bundle for instr_fetch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
  logic [31:0] initialPCval;
  logic        start;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchOffset;
  logic        jump;
  logic [25:0] jumpIndex;
  logic        imemWrEn;
  logic [31:0] imemWrAddr;
  logic [31:0] imemWrData;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instruction;
  logic        instrValid;
  logic        halted;
  logic        fault;

  modport master (
    output initialPCval, start, stall, branchTaken, branchOffset, jump, jumpIndex,
    output imemWrEn, imemWrAddr, imemWrData,
    input  pc, pcPlus4, instruction, instrValid, halted, fault
  );

  modport slave (
    input  initialPCval, start, stall, branchTaken, branchOffset, jump, jumpIndex,
    input  imemWrEn, imemWrAddr, imemWrData,
    output pc, pcPlus4, instruction, instrValid, halted, fault
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : PC sequencer with loadable instruction memory, branch/jump, halt/fault.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic              run,
  input  logic              reset,
  instr_fetch_unit_if.slave bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        halted_q;
  logic        fault_q;
  logic [31:0] mem [IMEM_DEPTH];

  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        pc_legal;
  logic        unused_bits;

  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = mem[pc_q[AW+1:2]];
  // Depth is a power of two, so "word index < depth" is "upper bits all zero".
  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q[31:AW+2] == '0);

  assign unused_bits = ^{bus.imemWrAddr[31:AW+2], bus.imemWrAddr[1:0],
                         bus.branchOffset[31:30]};

  always_comb begin
    pc_d = pc_plus4;
    if (bus.jump) begin
      pc_d = {pc_plus4[31:28], bus.jumpIndex, 2'b00};
    end else if (bus.branchTaken) begin
      pc_d = pc_plus4 + {bus.branchOffset[29:0], 2'b00};
    end
  end

  always_ff @(posedge run) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= bus.initialPCval;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_q <= RUN;
        end
        RUN: begin
          if (!pc_legal) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (bus.stall) begin
            state_q <= RUN;
          end else if (instr == HALT_WORD) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Memory has no reset; loader writes land only while idle and not in reset.
  always_ff @(posedge run) begin
    if (!reset && state_q == IDLE && bus.imemWrEn) begin
      mem[bus.imemWrAddr[AW+1:2]] <= bus.imemWrData;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pcPlus4     = pc_plus4;
  assign bus.instruction = instr;
  assign bus.instrValid  = (state_q == RUN) && pc_legal;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed scenarios plus randomized run against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
  localparam int          DEPTH = 256;
  localparam logic [31:0] HW    = 32'hFFFFFFFF;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic run   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] prog [4];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .HALT_WORD(HW)) dut (
    .run   (run),
    .reset (reset),
    .bus   (bus)
  );

  always #5 run = ~run;

  task automatic tick;
    @(posedge run);
    #1;
  endtask

  task automatic clear_inputs;
    bus.start = 1'b0; bus.stall = 1'b0; bus.branchTaken = 1'b0; bus.branchOffset = 32'h0;
    bus.jump = 1'b0; bus.jumpIndex = 26'h0; bus.imemWrEn = 1'b0;
    bus.imemWrAddr = 32'h0; bus.imemWrData = 32'h0;
  endtask

  task automatic do_reset(input logic [31:0] init);
    bus.initialPCval = init;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic write_word(input int idx, input logic [31:0] data);
    bus.imemWrEn = 1'b1; bus.imemWrAddr = 32'(idx * 4); bus.imemWrData = data;
    tick;
    bus.imemWrEn = 1'b0;
  endtask

  task automatic start_run;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs;
    do_reset(32'h0);
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    total++; if (bus.instrValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.instrValid); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    repeat (3) tick;
    total++; if (bus.pc !== 32'h0 || bus.instrValid !== 1'b0) begin
      bad++; $display("FAIL idle_hold: pc=%h valid=%b want pc=0 valid=0", bus.pc, bus.instrValid);
    end
  endtask

  task automatic test_program;
    do_reset(32'h0);
    for (int i = 0; i < 4; i++) write_word(i, prog[i]);
    for (int i = 4; i < 32; i++) write_word(i, 32'h0);
    start_run;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.pc !== 32'(4 * i) || bus.instrValid !== 1'b1) begin
        bad++; $display("FAIL prog_pc[%0d]: pc=%h valid=%b want pc=%h valid=1", i, bus.pc, bus.instrValid, 4 * i);
      end
      total++; if (bus.instruction !== prog[i]) begin
        bad++; $display("FAIL prog_instr[%0d]: got %h want %h", i, bus.instruction, prog[i]);
      end
      total++; if (bus.pcPlus4 !== 32'(4 * i + 4)) begin
        bad++; $display("FAIL prog_pcplus4[%0d]: got %h want %h", i, bus.pcPlus4, 4 * i + 4);
      end
      tick;
    end
    total++; if (bus.halted !== 1'b1 || bus.pc !== 32'hC || bus.instrValid !== 1'b0) begin
      bad++; $display("FAIL halt: halted=%b pc=%h valid=%b want 1 0000000c 0", bus.halted, bus.pc, bus.instrValid);
    end
    bus.start = 1'b1; tick; tick; bus.start = 1'b0;
    total++; if (bus.halted !== 1'b1 || bus.pc !== 32'hC || bus.fault !== 1'b0) begin
      bad++; $display("FAIL halt_sticky: halted=%b pc=%h fault=%b want 1 0000000c 0", bus.halted, bus.pc, bus.fault);
    end
  endtask

  task automatic test_branch_jump;
    do_reset(32'h0);
    start_run; tick; tick;
    total++; if (bus.pc !== 32'h8) begin bad++; $display("FAIL bj_setup: got %h want %h", bus.pc, 32'h8); end
    bus.branchTaken = 1'b1; bus.branchOffset = 32'hFFFFFFFE;
    tick;
    bus.branchTaken = 1'b0;
    total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL branch_back: got %h want %h", bus.pc, 32'h4); end
    tick;
    bus.branchTaken = 1'b1; bus.branchOffset = 32'hFFFFFFFE; bus.jump = 1'b1; bus.jumpIndex = 26'h10;
    tick;
    clear_inputs;
    total++; if (bus.pc !== 32'h40 || bus.instrValid !== 1'b1) begin
      bad++; $display("FAIL jump_wins: pc=%h valid=%b want 00000040 1", bus.pc, bus.instrValid);
    end
  endtask

  task automatic test_stall;
    do_reset(32'h0);
    bus.imemWrEn = 1'b1; bus.imemWrAddr = 32'h17; bus.imemWrData = 32'hABCD0001; bus.start = 1'b1;
    tick;
    clear_inputs;
    tick;
    bus.stall = 1'b1; bus.branchTaken = 1'b1; bus.branchOffset = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (bus.pc !== 32'h4 || bus.instrValid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d]: pc=%h valid=%b want 00000004 1", i, bus.pc, bus.instrValid);
      end
    end
    bus.stall = 1'b0;
    tick;
    clear_inputs;
    total++; if (bus.pc !== 32'h14) begin bad++; $display("FAIL stall_release: got %h want %h", bus.pc, 32'h14); end
    total++; if (bus.instruction !== 32'hABCD0001) begin
      bad++; $display("FAIL write_with_start: got %h want %h", bus.instruction, 32'hABCD0001);
    end
  endtask

  task automatic test_fault;
    do_reset(32'h2);
    start_run;
    total++; if (bus.instrValid !== 1'b0 || bus.fault !== 1'b0) begin
      bad++; $display("FAIL misalign_run: valid=%b fault=%b want 0 0", bus.instrValid, bus.fault);
    end
    tick;
    total++; if (bus.fault !== 1'b1 || bus.pc !== 32'h2 || bus.instrValid !== 1'b0) begin
      bad++; $display("FAIL misalign_fault: fault=%b pc=%h valid=%b want 1 00000002 0", bus.fault, bus.pc, bus.instrValid);
    end
    bus.start = 1'b1; tick; tick; bus.start = 1'b0;
    total++; if (bus.fault !== 1'b1 || bus.pc !== 32'h2) begin
      bad++; $display("FAIL fault_sticky: fault=%b pc=%h want 1 00000002", bus.fault, bus.pc);
    end
    do_reset(32'h0);
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL fault_reset: got %b want 0", bus.fault); end
    start_run;
    bus.jump = 1'b1; bus.jumpIndex = 26'(DEPTH);
    tick;
    bus.jump = 1'b0;
    total++; if (bus.pc !== 32'h400 || bus.instrValid !== 1'b0 || bus.fault !== 1'b0) begin
      bad++; $display("FAIL jump_oob: pc=%h valid=%b fault=%b want 00000400 0 0", bus.pc, bus.instrValid, bus.fault);
    end
    tick;
    total++; if (bus.fault !== 1'b1 || bus.pc !== 32'h400) begin
      bad++; $display("FAIL jump_oob_fault: fault=%b pc=%h want 1 00000400", bus.fault, bus.pc);
    end
  endtask

  task automatic test_reset_midrun;
    do_reset(32'h0);
    start_run;
    bus.jump = 1'b1; bus.jumpIndex = 26'h8;
    tick;
    bus.jump = 1'b0;
    total++; if (bus.pc !== 32'h20) begin bad++; $display("FAIL midrun_setup: got %h want %h", bus.pc, 32'h20); end
    bus.imemWrEn = 1'b1; bus.imemWrAddr = 32'h0; bus.imemWrData = 32'hDEADBEEF;
    tick;
    bus.imemWrAddr = 32'h4; bus.imemWrData = 32'h12345678;
    bus.initialPCval = 32'h10; reset = 1'b1;
    tick;
    reset = 1'b0; bus.imemWrEn = 1'b0;
    total++; if (bus.pc !== 32'h10 || bus.instrValid !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      bad++; $display("FAIL midrun_reset: pc=%h valid=%b halted=%b fault=%b want 00000010 0 0 0",
                      bus.pc, bus.instrValid, bus.halted, bus.fault);
    end
    total++; if (bus.instruction !== 32'h0) begin bad++; $display("FAIL mem_word4: got %h want %h", bus.instruction, 32'h0); end
    do_reset(32'h4);
    total++; if (bus.instruction !== prog[1]) begin
      bad++; $display("FAIL reset_write_discard: got %h want %h", bus.instruction, prog[1]);
    end
    do_reset(32'h0);
    total++; if (bus.instruction !== prog[0]) begin
      bad++; $display("FAIL run_write_ignored: got %h want %h", bus.instruction, prog[0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, n_pc, d;
    int          m_mode, n_mode, off;
    logic        legal, exp_valid;
    clear_inputs;
    do_reset(32'h0);
    m_mode = M_IDLE; m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      d = ($urandom_range(0, 15) == 0) ? HW : $urandom;
      write_word(i, d);
      m_mem[i] = d;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = ($urandom_range(0, 39) == 0);
      bus.initialPCval = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.branchTaken = ($urandom_range(0, 3) == 0);
      off = int'($urandom_range(0, 15)) - 8;
      bus.branchOffset = off;
      bus.jump = ($urandom_range(0, 7) == 0);
      bus.jumpIndex = 26'($urandom_range(0, DEPTH + 40));
      bus.imemWrEn = ($urandom_range(0, 1) == 0);
      bus.imemWrAddr = $urandom;
      bus.imemWrData = $urandom;

      legal = (m_pc % 32'd4 == 32'd0) && (m_pc / 32'd4 < 32'(DEPTH));
      n_mode = m_mode; n_pc = m_pc;
      if (reset) begin
        n_mode = M_IDLE; n_pc = bus.initialPCval;
      end else if (m_mode == M_IDLE) begin
        if (bus.imemWrEn) m_mem[(bus.imemWrAddr / 32'd4) % 32'(DEPTH)] = bus.imemWrData;
        if (bus.start) n_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (!legal) n_mode = M_FAULT;
        else if (bus.stall) n_mode = M_RUN;
        else if (m_mem[m_pc / 32'd4] == HW) n_mode = M_HALT;
        else if (bus.jump) n_pc = ((m_pc + 32'd4) & 32'hF0000000) | ({6'b0, bus.jumpIndex} * 32'd4);
        else if (bus.branchTaken) n_pc = m_pc + 32'd4 + bus.branchOffset * 32'd4;
        else n_pc = m_pc + 32'd4;
      end

      tick;
      m_mode = n_mode; m_pc = n_pc;
      legal = (m_pc % 32'd4 == 32'd0) && (m_pc / 32'd4 < 32'(DEPTH));
      exp_valid = (m_mode == M_RUN) && legal;

      total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, bus.pc, m_pc); end
      total++; if (bus.pcPlus4 !== m_pc + 32'd4) begin
        bad++; $display("FAIL rnd_pcplus4@%0d: got %h want %h", cyc, bus.pcPlus4, m_pc + 32'd4);
      end
      total++; if (bus.instrValid !== exp_valid) begin
        bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.instrValid, exp_valid);
      end
      total++; if (bus.halted !== (m_mode == M_HALT)) begin
        bad++; $display("FAIL rnd_halted@%0d: got %b want %b", cyc, bus.halted, m_mode == M_HALT);
      end
      total++; if (bus.fault !== (m_mode == M_FAULT)) begin
        bad++; $display("FAIL rnd_fault@%0d: got %b want %b", cyc, bus.fault, m_mode == M_FAULT);
      end
      if (legal) begin
        total++; if (bus.instruction !== m_mem[m_pc / 32'd4]) begin
          bad++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, bus.instruction, m_mem[m_pc / 32'd4]);
        end
      end
    end
    reset = 1'b0;
    clear_inputs;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    prog[0] = 32'h20080005; prog[1] = 32'h20090003; prog[2] = 32'h01095020; prog[3] = 32'hFFFFFFFF;
    bus.initialPCval = 32'h0;
    clear_inputs;
    test_reset;
    test_program;
    test_branch_jump;
    test_stall;
    test_fault;
    test_reset_midrun;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
